// File: rtl/atm.sv
// ATM controller: card/PIN authentication, a transaction menu and a
// ten-account store of PINs, balances and lockout counters.
module atm (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  operation,
   input  logic [3:0]  acc_num,
   input  logic [15:0] pin,
   input  logic [15:0] newPin,
   input  logic [31:0] amount,
   input  logic        language,
   output logic [31:0] balance,
   output logic        success,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_AUTH       = 3'd0,
      S_MENU       = 3'd1,
      S_WITHDRAW   = 3'd2,
      S_BALANCE    = 3'd3,
      S_DEPOSIT    = 3'd4,
      S_CHANGE_PIN = 3'd5,
      S_ERROR      = 3'd6,
      S_IDLE       = 3'd7
   } state_t;

   state_t      cur_state;
   logic [3:0]  cur_acc;
   logic        cur_lang;

   // Entries 0 and 11..15 exist only so a 4-bit account number can index
   // directly; they never authenticate, so their contents are never used.
   logic [31:0] bal_mem  [16];
   logic [15:0] pin_mem  [16];
   logic [1:0]  fail_mem [16];

   logic        acc_valid;
   logic        auth_ok;
   logic [31:0] cur_bal;
   logic [32:0] dep_sum;

   // Factory PIN for each account, restored on every reset.
   function automatic logic [15:0] default_pin(input logic [3:0] a);
      case (a)
         4'd1:    return 16'd1234;
         4'd2:    return 16'd2345;
         4'd3:    return 16'd3456;
         4'd4:    return 16'd4567;
         4'd5:    return 16'd5678;
         4'd6:    return 16'd6789;
         4'd7:    return 16'd7890;
         4'd8:    return 16'd8901;
         4'd9:    return 16'd9012;
         4'd10:   return 16'd123;
         default: return 16'd0;
      endcase
   endfunction

   // Operation code that keeps a transaction state occupied.
   function automatic logic [2:0] hold_code(input state_t s);
      case (s)
         S_WITHDRAW:   return 3'd1;
         S_CHANGE_PIN: return 3'd2;
         S_BALANCE:    return 3'd3;
         S_DEPOSIT:    return 3'd5;
         default:      return 3'd0;
      endcase
   endfunction

   // A lock is a saturated fail counter; the extra bit of dep_sum flags overflow.
   assign acc_valid = (cur_acc != 4'd0) && (cur_acc <= 4'd10);
   assign auth_ok   = acc_valid && (fail_mem[cur_acc] != 2'd3) && (pin_mem[cur_acc] == pin);
   assign cur_bal   = bal_mem[cur_acc];
   assign dep_sum   = {1'b0, cur_bal} + {1'b0, amount};
   assign state     = cur_state;

   // Session FSM; each transaction commits on the edge that enters its state.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            pin_mem[i]  <= default_pin(4'(i));
            bal_mem[i]  <= (i >= 1 && i <= 10) ? 32'd1000 : 32'd0;
            fail_mem[i] <= 2'd0;
         end
         cur_state <= S_IDLE;
         cur_acc   <= 4'd0;
         cur_lang  <= 1'b0;
         balance   <= 32'd0;
         success   <= 1'b0;
      end else begin
         case (cur_state)
            S_IDLE: begin
               if (acc_num != 4'd0) begin
                  cur_acc   <= acc_num;
                  cur_lang  <= language;
                  cur_state <= S_AUTH;
               end
            end
            S_AUTH: begin
               if (auth_ok) begin
                  cur_state         <= S_MENU;
                  success           <= 1'b1;
                  balance           <= cur_bal;
                  fail_mem[cur_acc] <= 2'd0;
               end else begin
                  cur_state <= S_ERROR;
                  success   <= 1'b0;
                  balance   <= 32'd0;
                  if (acc_valid && fail_mem[cur_acc] != 2'd3)
                     fail_mem[cur_acc] <= fail_mem[cur_acc] + 2'd1;
               end
            end
            S_ERROR: begin
               cur_state <= S_IDLE;
            end
            default: begin
               if (acc_num != cur_acc) begin
                  cur_acc   <= acc_num;
                  cur_lang  <= language;
                  cur_state <= S_AUTH;
               end else if (cur_state == S_MENU) begin
                  case (operation)
                     3'd1: begin
                        cur_state <= S_WITHDRAW;
                        if (amount <= cur_bal) begin
                           bal_mem[cur_acc] <= cur_bal - amount;
                           balance          <= cur_bal - amount;
                           success          <= 1'b1;
                        end else begin
                           balance <= cur_bal;
                           success <= 1'b0;
                        end
                     end
                     3'd2: begin
                        cur_state        <= S_CHANGE_PIN;
                        pin_mem[cur_acc] <= newPin;
                        balance          <= cur_bal;
                        success          <= 1'b1;
                     end
                     3'd3: begin
                        cur_state <= S_BALANCE;
                        balance   <= cur_bal;
                        success   <= 1'b1;
                     end
                     3'd5: begin
                        cur_state <= S_DEPOSIT;
                        if (!dep_sum[32]) begin
                           bal_mem[cur_acc] <= dep_sum[31:0];
                           balance          <= dep_sum[31:0];
                           success          <= 1'b1;
                        end else begin
                           balance <= cur_bal;
                           success <= 1'b0;
                        end
                     end
                     3'd6, 3'd7: begin
                        cur_state <= S_IDLE;
                        balance   <= 32'd0;
                     end
                     default: begin
                     end
                  endcase
               end else if (operation != hold_code(cur_state)) begin
                  cur_state <= S_MENU;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_atm.sv
// Self-checking bench for atm: a per-account behavioural model compared every
// cycle, plus directed literal checks at the key points of each scenario.
module tb_atm;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  operation;
   logic [3:0]  acc_num;
   logic [15:0] pin;
   logic [15:0] newPin;
   logic [31:0] amount;
   logic        language;
   logic [31:0] balance;
   logic        success;
   logic [2:0]  state;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   // Behavioural model of the account store and session
   int     m_state   = 7;
   longint m_bal_out = 0;
   bit     m_succ    = 1'b0;
   int     m_acc     = 0;
   longint m_bal  [16];
   int     m_pin  [16];
   int     m_fail [16];

   atm dut (
      .clk       (clk),
      .rst       (rst),
      .operation (operation),
      .acc_num   (acc_num),
      .pin       (pin),
      .newPin    (newPin),
      .amount    (amount),
      .language  (language),
      .balance   (balance),
      .success   (success),
      .state     (state)
   );

   always #5 clk = ~clk;

   function automatic int default_pin_of(int a);
      int pins [11];
      pins = '{0, 1234, 2345, 3456, 4567, 5678, 6789, 7890, 8901, 9012, 123};
      if (a >= 1 && a <= 10) return pins[a];
      return -1;
   endfunction

   function automatic int code_for(int st);
      case (st)
         2: return 1;
         3: return 3;
         4: return 5;
         5: return 2;
         default: return -1;
      endcase
   endfunction

   function automatic int target_for(int op);
      case (op)
         1: return 2;
         2: return 5;
         3: return 3;
         5: return 4;
         6, 7: return 7;
         default: return 1;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_bal[i]  = (i >= 1 && i <= 10) ? 1000 : 0;
         m_pin[i]  = default_pin_of(i);
         m_fail[i] = 0;
      end
      m_state   = 7;
      m_bal_out = 0;
      m_succ    = 1'b0;
      m_acc     = 0;
   endtask

   task automatic model_transact(int st);
      case (st)
         2: begin
            if (longint'(amount) <= m_bal[m_acc]) begin
               m_bal[m_acc] = m_bal[m_acc] - longint'(amount);
               m_succ = 1'b1;
            end else m_succ = 1'b0;
         end
         4: begin
            if (m_bal[m_acc] + longint'(amount) < 64'sd4294967296) begin
               m_bal[m_acc] = m_bal[m_acc] + longint'(amount);
               m_succ = 1'b1;
            end else m_succ = 1'b0;
         end
         5: begin
            m_pin[m_acc] = int'(newPin);
            m_succ = 1'b1;
         end
         default: m_succ = 1'b1;
      endcase
      m_bal_out = m_bal[m_acc];
   endtask

   // Model advances on the same edge as the DUT, from the same inputs
   always @(posedge clk) begin
      if (rst) model_reset();
      else if ((m_state >= 1 && m_state <= 5) && int'(acc_num) != m_acc) begin
         m_acc   = int'(acc_num);
         m_state = 0;
      end else begin
         case (m_state)
            7: if (acc_num != 4'd0) begin
               m_acc   = int'(acc_num);
               m_state = 0;
            end
            0: begin
               if (m_acc >= 1 && m_acc <= 10 && m_fail[m_acc] < 3 && m_pin[m_acc] == int'(pin)) begin
                  m_state = 1; m_succ = 1'b1; m_bal_out = m_bal[m_acc]; m_fail[m_acc] = 0;
               end else begin
                  m_state = 6; m_succ = 1'b0; m_bal_out = 0;
                  if (m_acc >= 1 && m_acc <= 10) m_fail[m_acc] = m_fail[m_acc] + 1;
               end
            end
            6: m_state = 7;
            1: begin
               int t;
               t = target_for(int'(operation));
               if (t == 7) begin
                  m_state = 7; m_bal_out = 0;
               end else if (t != 1) begin
                  m_state = t;
                  model_transact(t);
               end
            end
            default: if (int'(operation) != code_for(m_state)) m_state = 1;
         endcase
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmp_en) begin
         checks += 1;
         if (int'(state) != m_state || longint'(balance) != m_bal_out || success != m_succ) begin
            errors += 1;
            $display("[TB] FAIL model t=%0t: got state=%0d balance=%0d success=%0d, expected state=%0d balance=%0d success=%0d",
                     $time, state, balance, success, m_state, m_bal_out, m_succ);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int acc, input int p, input int op, input longint amt, input int np);
      acc_num   = 4'(acc);
      pin       = 16'(p);
      operation = 3'(op);
      amount    = 32'(amt);
      newPin    = 16'(np);
   endtask

   task automatic checkOutput(input string name, input int es, input longint eb, input bit esu);
      checks += 1;
      if (int'(state) != es || longint'(balance) != eb || success != esu) begin
         errors += 1;
         $display("[TB] FAIL %s: got state=%0d balance=%0d success=%0d, expected state=%0d balance=%0d success=%0d",
                  name, state, balance, success, es, eb, esu);
      end
   endtask

   initial begin
      rst = 1'b1; language = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      step();
      cmp_en = 1'b1;
      checkOutput("reset", 7, 0, 0);
      rst = 1'b0;

      $display("[TB] authenticate acc1 and show balance");
      applyStimulus(1, 1234, 3, 0, 0);
      step(); checkOutput("auth_entry", 0, 0, 0);
      step(); checkOutput("menu_after_auth", 1, 1000, 1);
      step(); checkOutput("show_balance", 3, 1000, 1);
      step(); checkOutput("balance_held", 3, 1000, 1);

      $display("[TB] deposit once while held");
      applyStimulus(1, 1234, 5, 1000, 0);
      step(); checkOutput("back_to_menu", 1, 1000, 1);
      step(); checkOutput("deposit_entry", 4, 2000, 1);
      step(); step(); checkOutput("deposit_once", 4, 2000, 1);
      applyStimulus(1, 1234, 3, 1000, 0);
      step(); step(); checkOutput("balance_after_deposit", 3, 2000, 1);

      $display("[TB] switch to acc2 mid-session");
      language = 1'b1;
      applyStimulus(2, 2345, 3, 0, 0);
      step(); checkOutput("switch_auth", 0, 2000, 1);
      step(); checkOutput("switch_menu", 1, 1000, 1);
      step(); checkOutput("switch_balance", 3, 1000, 1);
      applyStimulus(2, 2345, 7, 0, 0);
      step(); step(); checkOutput("exit_idle", 7, 0, 1);
      applyStimulus(0, 0, 0, 0, 0);
      step();

      $display("[TB] reset in the middle of a deposit");
      applyStimulus(1, 1234, 5, 500, 0);
      step(); step(); step(); checkOutput("deposit_before_reset", 4, 2500, 1);
      rst = 1'b1;
      step(); checkOutput("reset_mid_txn", 7, 0, 0);
      rst = 1'b0;
      applyStimulus(0, 0, 0, 0, 0);
      step();

      $display("[TB] withdraw rules and deposit overflow");
      applyStimulus(1, 1234, 1, 5000, 0);
      step(); step(); step(); checkOutput("withdraw_too_much", 2, 1000, 0);
      amount = 32'd400;
      step(); checkOutput("withdraw_held_no_change", 2, 1000, 0);
      applyStimulus(1, 1234, 0, 400, 0); step();
      applyStimulus(1, 1234, 1, 400, 0);
      step(); checkOutput("withdraw_400", 2, 600, 1);
      applyStimulus(1, 1234, 0, 600, 0); step();
      applyStimulus(1, 1234, 1, 600, 0);
      step(); checkOutput("withdraw_exact", 2, 0, 1);
      applyStimulus(1, 1234, 0, 0, 0); step();
      applyStimulus(1, 1234, 5, 32'hFFFF_FFFF, 0);
      step(); checkOutput("deposit_to_max", 4, 64'h0000_0000_FFFF_FFFF, 1);
      applyStimulus(1, 1234, 0, 1, 0); step();
      applyStimulus(1, 1234, 5, 1, 0);
      step(); checkOutput("deposit_overflow", 4, 64'h0000_0000_FFFF_FFFF, 0);

      $display("[TB] change PIN");
      applyStimulus(1, 1234, 0, 0, 0); step();
      applyStimulus(1, 1234, 2, 0, 16'hBEEF);
      step(); checkOutput("change_pin", 5, 64'h0000_0000_FFFF_FFFF, 1);
      applyStimulus(1, 1234, 7, 0, 0);
      step(); step();
      applyStimulus(0, 0, 0, 0, 0); step();
      applyStimulus(1, 1234, 3, 0, 0);
      step(); step(); checkOutput("old_pin_rejected", 6, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      step(); checkOutput("error_to_idle", 7, 0, 0);
      applyStimulus(1, 16'hBEEF, 3, 0, 0);
      step(); step(); checkOutput("new_pin_accepted", 1, 64'h0000_0000_FFFF_FFFF, 1);
      applyStimulus(1, 16'hBEEF, 7, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0); step();

      $display("[TB] invalid account");
      applyStimulus(12, 0, 0, 0, 0);
      step(); step(); checkOutput("invalid_account", 6, 0, 0);
      applyStimulus(0, 0, 0, 0, 0); step();

      $display("[TB] lockout after three bad PINs");
      applyStimulus(3, 1111, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(); step(); checkOutput("bad_pin", 6, 0, 0);
         step();
      end
      pin = 16'd3456;
      step(); step(); checkOutput("locked", 6, 0, 0);
      applyStimulus(0, 0, 0, 0, 0); step();
      rst = 1'b1; step(); rst = 1'b0;
      applyStimulus(3, 3456, 3, 0, 0);
      step(); step(); step(); checkOutput("unlock_after_reset", 3, 1000, 1);
      applyStimulus(3, 3456, 7, 0, 0);
      step(); step();
      applyStimulus(1, 1234, 0, 0, 0);
      step(); step(); checkOutput("pin_restored", 1, 1000, 1);
      step(); checkOutput("menu_idle_op", 1, 1000, 1);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/atm.md
ATM -- requirements
Module: atm

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 operation  input  3  requested transaction: 0 none, 1 withdraw, 2 change PIN, 3 show balance, 4 reserved (no-op), 5 deposit, 6/7 exit.
REQ-004 acc_num  input  4  account number; 0 means no card inserted.
REQ-005 pin  input  16  entered PIN, compared as a 16-bit binary value.
REQ-006 newPin  input  16  replacement PIN for operation 2.
REQ-007 amount  input  32  unsigned transaction amount for withdraw/deposit.
REQ-008 language  input  1  display language (0 English, 1 Arabic); latched at authentication, no effect on other outputs.
REQ-009 balance  output  32  registered balance of the authenticated account; 0 when no session.
REQ-010 success  output  1  registered result of the last authentication or transaction (1 ok, 0 fail).
REQ-011 state  output  3  registered current FSM state code.

Function
REQ-012 Account store: accounts 1..10 valid; 11..15 and 0 invalid.
REQ-013 Default PINs (decimal): acc1 1234, acc2 2345, acc3 3456, acc4 4567, acc5 5678, acc6 6789, acc7 7890, acc8 8901, acc9 9012, acc10 123.
REQ-014 Default balance of every valid account: 1000.
REQ-015 State codes: 7 IDLE, 0 AUTH, 1 MENU, 2 WITHDRAW, 3 BALANCE, 4 DEPOSIT, 5 CHANGE_PIN, 6 ERROR.
REQ-016 IDLE: if acc_num != 0, latch acc_num/language and go to AUTH; otherwise stay.
REQ-017 AUTH: valid account with pin matching stored PIN -> MENU, success=1, balance=account balance, fail counter of that account cleared.
REQ-018 AUTH failure (invalid account, mismatched PIN, or locked account) -> ERROR, success=0, balance=0, that account's fail counter incremented.
REQ-019 Three consecutive failures lock an account until reset; a locked account never authenticates.
REQ-020 ERROR lasts one cycle, then IDLE.
REQ-021 MENU: operation 1/2/3/5 -> states 2/5/3/4 respectively; 0 or 4 -> stay MENU; 6 or 7 -> IDLE, balance=0.
REQ-022 Any session state (MENU or 2..5): acc_num differing from latched account -> AUTH with new acc_num latched.
REQ-023 Transaction executes exactly once, on the cycle of entry into its state.
REQ-024 Withdraw: amount <= balance -> balance -= amount, success=1; else balance unchanged, success=0.
REQ-025 Deposit: balance + amount < 2^32 -> balance += amount, success=1; on overflow balance unchanged, success=0.
REQ-026 Change PIN: stored PIN := newPin, success=1.
REQ-027 Show balance: no data change, success=1.
REQ-028 Operation state is held while operation equals its code; on any other code -> MENU next cycle.
REQ-029 balance output always mirrors the stored balance of the authenticated account after updates.
REQ-030 Latency: acc_num/pin/operation applied from IDLE reaches the operation state on the 3rd rising edge (IDLE->AUTH->MENU->op).

Reset
REQ-031 rst=1 at a rising edge: state=7, balance=0, success=0; all PINs, balances and fail counters restored to defaults; overrides any in-progress transaction.
REQ-032 Reset applied mid-transaction leaves no partial update; account data equal defaults after reset.

Verification
REQ-033 rst=1 one cycle -> state=7, balance=0, success=0.
REQ-034 acc_num=1, pin=1234, operation=3 from IDLE -> state 0,1,3 on edges 1-3; state stays 3, balance=1000, success=1.
REQ-035 Session acc1, operation changes 3->5 with amount=1000 -> MENU, then DEPOSIT, balance=2000 exactly once while held; back to 3 -> balance 2000.
REQ-036 In session switch acc_num=2, pin=2345, operation=3 -> AUTH, MENU, BALANCE, balance=1000.
REQ-037 acc_num=1, amount=5000, operation=1 -> success=0, balance stays 1000; amount=400 -> balance=600.
REQ-038 acc_num=3, pin=1111 three times -> ERROR each, success=0; fourth try with pin=3456 still fails (locked) until rst.
